// File: rtl/ahb_sub_mem_pkg.sv
// Shared AHB-lite encodings and the subordinate FSM state type.
package ahb_sub_mem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_sub_mem_if.sv
// AHB-lite bus bundle between a master and this subordinate.
interface ahb_sub_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [1:0]            htrans;
  logic [2:0]            hburst;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, htrans, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, htrans, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sub_ram.sv
// Word-organised RAM with async read and byte-lane sync write.
module ahb_sub_ram
  import ahb_sub_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W+1:0] addr,
  input  logic [2:0]       size,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH];
  logic [3:0]  be;

  always_comb begin
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr[1:0];
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[addr[IDX_W+1:2]][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[addr[IDX_W+1:2]];
endmodule

// File: rtl/ahb_sub_mem.sv
// AHB-lite subordinate fronting an on-chip RAM, with wait states and ERROR response.
// state   | meaning
// IDLE    | no transfer in data phase
// WAIT    | OKAY data phase stretched, counter running
// DATA    | OKAY data phase completing (write commits / read data driven)
// ERR1    | first ERROR cycle, hreadyout low
// ERR2    | second ERROR cycle, new address may be accepted
module ahb_sub_mem
  import ahb_sub_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic          i_hclk,
  input logic          i_hreset,
  ahb_sub_mem_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  state_t                state_q, state_d, launch;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W+1:0]      addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  accept, legal, misaligned, in_range, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_burst;

  assign unused_burst = ^bus.hburst;
  assign accept       = bus.hsel & bus.hready & bus.htrans[1];

  always_comb begin
    case (bus.hsize)
      HSIZE_HALF: misaligned = bus.haddr[0];
      HSIZE_WORD: misaligned = |bus.haddr[1:0];
      default:    misaligned = 1'b0;
    endcase
  end

  // Full-width compare so any nonzero upper address bit is out of range.
  assign in_range = {2'b00, bus.haddr[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(MEM_DEPTH);
  assign legal    = (bus.hsize <= HSIZE_WORD) && !misaligned && in_range;

  always_comb begin
    launch = ST_IDLE;
    if (accept) begin
      if (!legal)               launch = ST_ERR1;
      else if (WAIT_STATES > 0) launch = ST_WAIT;
      else                      launch = ST_DATA;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    ram_we        = 1'b0;
    case (state_q)
      ST_IDLE: state_d = launch;
      ST_WAIT: begin
        bus.hreadyout = 1'b0;
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DATA: begin
        ram_we  = write_q;
        state_d = launch;
      end
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
        state_d       = ST_ERR2;
      end
      ST_ERR2: begin
        bus.hresp = 1'b1;
        state_d   = launch;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_WAIT && state_q != ST_WAIT) cnt_d = 4'(WAIT_STATES - 1);
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= HSIZE_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.haddr[IDX_W+1:0];
        write_q <= bus.hwrite;
        size_q  <= bus.hsize;
      end
    end
  end

  assign bus.hrdata = (state_q == ST_DATA && !write_q) ? ram_rdata : '0;

  ahb_sub_ram #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (i_hclk),
    .we    (ram_we),
    .addr  (addr_q),
    .size  (size_q),
    .wdata (bus.hwdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_ahb_sub_mem.sv
// Bench for ahb_sub_mem: three instances (0, 2 and 3 wait states) behind one master driver.
module tb_ahb_sub_mem;
  import ahb_sub_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          cur = 0;
  logic        m_hsel = 1'b0;
  logic [31:0] m_haddr = '0;
  logic        m_hwrite = 1'b0;
  logic [2:0]  m_hsize = '0;
  logic [1:0]  m_htrans = '0;
  logic [2:0]  m_hburst = '0;
  logic [31:0] m_hwdata = '0;

  logic        obs_ready [3];
  logic        obs_resp  [3];
  logic [31:0] obs_data  [3];

  ahb_sub_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : g + 1;
    assign bus[g].hsel   = m_hsel && (cur == g);
    assign bus[g].haddr  = m_haddr;
    assign bus[g].hwrite = m_hwrite;
    assign bus[g].hsize  = m_hsize;
    assign bus[g].htrans = m_htrans;
    assign bus[g].hburst = m_hburst;
    assign bus[g].hwdata = m_hwdata;
    assign bus[g].hready = bus[g].hreadyout;
    assign obs_ready[g]  = bus[g].hreadyout;
    assign obs_resp[g]   = bus[g].hresp;
    assign obs_data[g]   = bus[g].hrdata;
    ahb_sub_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES(W)
    ) dut (
      .i_hclk  (clk),
      .i_hreset(rst),
      .bus     (bus[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected data-phase cycles: 0 wait, 1 read data, 2 write commit, 3 error-1, 4 error-2
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [2:0]  size;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [3][256];
  logic        started = 1'b0;

  function automatic int ws_of(int b);
    return (b == 0) ? 0 : b + 1;
  endfunction

  function automatic bit model_legal(logic [31:0] a, logic [2:0] s);
    return (s <= 3'd2) && ((a % (32'd1 << s)) == 0) && (a < 32'd1024);
  endfunction

  function automatic void model_write(int b, logic [31:0] a, logic [2:0] s, logic [31:0] d);
    for (int i = 0; i < (1 << s); i++) begin
      int ba;
      ba = int'(a) + i;
      mem_m[b][ba / 4][8 * (ba % 4) +: 8] = d[8 * (ba % 4) +: 8];
    end
  endfunction

  initial begin
    for (int b = 0; b < 3; b++)
      for (int w = 0; w < 256; w++) mem_m[b][w] = 'x;
  end

  always @(negedge clk) begin : cmp
    exp_t        e;
    exp_t        n;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_data;
    if (started) begin
      exp_rdy  = 1'b1;
      exp_resp = 1'b0;
      exp_data = '0;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          0: exp_rdy = 1'b0;
          1: exp_data = mem_m[cur][e.addr / 4];
          2: if (!rst) model_write(cur, e.addr, e.size, m_hwdata);
          3: begin exp_rdy = 1'b0; exp_resp = 1'b1; end
          default: exp_resp = 1'b1;
        endcase
      end
      chk("hready", 32'(obs_ready[cur]), 32'(exp_rdy));
      chk("hresp", 32'(obs_resp[cur]), 32'(exp_resp));
      if (!$isunknown(exp_data)) chk("hrdata", obs_data[cur], exp_data);
      if (rst) q.delete();
      else if (m_hsel && obs_ready[cur] && m_htrans[1]) begin
        n.addr = m_haddr;
        n.size = m_hsize;
        if (model_legal(m_haddr, m_hsize)) begin
          for (int i = 0; i < ws_of(cur); i++) begin n.kind = 0; q.push_back(n); end
          n.kind = m_hwrite ? 2 : 1;
          q.push_back(n);
        end else begin
          n.kind = 3; q.push_back(n);
          n.kind = 4; q.push_back(n);
        end
      end
    end
  end

  // ---------------- master driver ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] wdata;
  } xf_t;

  xf_t         xq[$];
  logic [31:0] rd_got[$];
  int          cyc, low_cnt, resp_cnt;

  function automatic void add(logic [31:0] a, logic w, logic [2:0] s, logic [31:0] d,
                              logic [1:0] tr = HTRANS_NONSEQ, logic [2:0] b = HBURST_SINGLE);
    xf_t x;
    x.addr = a; x.wr = w; x.size = s; x.trans = tr; x.burst = b; x.wdata = d;
    xq.push_back(x);
  endfunction

  function automatic logic [31:0] pop_rd();
    if (rd_got.size() == 0) return 'x;
    return rd_got.pop_front();
  endfunction

  task automatic run();
    int n;
    n = xq.size();
    cyc = 0; low_cnt = 0; resp_cnt = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        m_hsel = 1'b1; m_haddr = xq[i].addr; m_hwrite = xq[i].wr; m_hsize = xq[i].size;
        m_htrans = xq[i].trans; m_hburst = xq[i].burst;
      end else begin
        m_hsel = 1'b0; m_htrans = HTRANS_IDLE;
      end
      m_hwdata = (i > 0 && xq[i-1].wr && xq[i-1].trans[1]) ? xq[i-1].wdata : 32'h0;
      for (int t = 0; ; t++) begin
        @(negedge clk);
        cyc++;
        if (!obs_ready[cur]) low_cnt++;
        if (obs_resp[cur]) resp_cnt++;
        if (obs_ready[cur]) begin
          if (i > 0 && !xq[i-1].wr && xq[i-1].trans[1] && !obs_resp[cur])
            rd_got.push_back(obs_data[cur]);
          break;
        end
        if (t > 50) begin
          n_chk++; n_fail++;
          $display("FAIL timeout: hready stuck low, got 0, expected 1");
          break;
        end
      end
      @(posedge clk); #1;
    end
    xq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_hready", 32'(obs_ready[0]), 32'd1);
    chk("reset_hrdata", obs_data[0], 32'h0);
    @(posedge clk); #1;

    // zero-wait write then read
    cur = 0;
    add(32'h10, 1, HSIZE_WORD, 32'hDEADBEEF);
    add(32'h10, 0, HSIZE_WORD, 0);
    run();
    chk("t1_rdata", pop_rd(), 32'hDEADBEEF);
    chk("t1_cycles", 32'(cyc), 32'd3);
    chk("t1_lows", 32'(low_cnt), 32'd0);

    // mixed-size writes into one word
    add(32'h20, 1, HSIZE_WORD, 32'h11223344);
    add(32'h21, 1, HSIZE_BYTE, 32'h0000AA00);
    add(32'h22, 1, HSIZE_HALF, 32'hBEEF0000);
    add(32'h20, 0, HSIZE_WORD, 0);
    run();
    chk("lanes_rdata", pop_rd(), 32'hBEEFAA44);

    // illegal transfers leave RAM untouched
    add(32'h00, 1, HSIZE_WORD, 32'hCAFEF00D);
    add(32'h400, 1, HSIZE_WORD, 32'h12345678);
    add(32'h02, 1, HSIZE_WORD, 32'h87654321);
    add(32'h10, 1, 3'b011, 32'h55555555);
    add(32'h00, 0, HSIZE_WORD, 0);
    add(32'h10, 0, HSIZE_WORD, 0);
    run();
    chk("err_lows", 32'(low_cnt), 32'd3);
    chk("err_resp_cycles", 32'(resp_cnt), 32'd6);
    chk("err_rd0", pop_rd(), 32'hCAFEF00D);
    chk("err_rd10", pop_rd(), 32'hDEADBEEF);

    // INCR4 writes then WRAP4 read from 0x48
    add(32'h40, 1, HSIZE_WORD, 1, HTRANS_NONSEQ, HBURST_INCR4);
    add(32'h44, 1, HSIZE_WORD, 2, HTRANS_SEQ, HBURST_INCR4);
    add(32'h48, 1, HSIZE_WORD, 3, HTRANS_SEQ, HBURST_INCR4);
    add(32'h4C, 1, HSIZE_WORD, 4, HTRANS_SEQ, HBURST_INCR4);
    add(32'h48, 0, HSIZE_WORD, 0, HTRANS_NONSEQ, HBURST_WRAP4);
    add(32'h4C, 0, HSIZE_WORD, 0, HTRANS_SEQ, HBURST_WRAP4);
    add(32'h40, 0, HSIZE_WORD, 0, HTRANS_SEQ, HBURST_WRAP4);
    add(32'h44, 0, HSIZE_WORD, 0, HTRANS_SEQ, HBURST_WRAP4);
    run();
    chk("burst_cycles", 32'(cyc), 32'd9);
    chk("burst_lows", 32'(low_cnt), 32'd0);
    chk("wrap_rd0", pop_rd(), 32'd3);
    chk("wrap_rd1", pop_rd(), 32'd4);
    chk("wrap_rd2", pop_rd(), 32'd1);
    chk("wrap_rd3", pop_rd(), 32'd2);

    // BUSY mid-burst
    add(32'h40, 0, HSIZE_WORD, 0, HTRANS_NONSEQ, HBURST_INCR);
    add(32'h44, 0, HSIZE_WORD, 0, HTRANS_BUSY, HBURST_INCR);
    add(32'h44, 0, HSIZE_WORD, 0, HTRANS_SEQ, HBURST_INCR);
    run();
    chk("busy_cycles", 32'(cyc), 32'd4);
    chk("busy_lows", 32'(low_cnt), 32'd0);
    chk("busy_rd0", pop_rd(), 32'd1);
    chk("busy_rd1", pop_rd(), 32'd2);

    // two wait states
    cur = 1;
    add(32'h10, 1, HSIZE_WORD, 32'h0BADF00D);
    add(32'h14, 1, HSIZE_WORD, 32'h600DCAFE);
    run();
    add(32'h10, 0, HSIZE_WORD, 0);
    run();
    chk("ws2_lows", 32'(low_cnt), 32'd2);
    chk("ws2_cycles", 32'(cyc), 32'd4);
    chk("ws2_rdata", pop_rd(), 32'h0BADF00D);
    add(32'h14, 0, HSIZE_WORD, 0);
    add(32'h10, 0, HSIZE_WORD, 0);
    run();
    chk("ws2_pair_lows", 32'(low_cnt), 32'd4);
    chk("ws2_pair_cycles", 32'(cyc), 32'd7);
    chk("ws2_pair_rd0", pop_rd(), 32'h600DCAFE);
    chk("ws2_pair_rd1", pop_rd(), 32'h0BADF00D);

    // reset during WAIT aborts the write
    cur = 2;
    add(32'h30, 1, HSIZE_WORD, 32'h00000A1D);
    run();
    m_hsel = 1'b1; m_haddr = 32'h30; m_hwrite = 1'b1; m_hsize = HSIZE_WORD;
    m_htrans = HTRANS_NONSEQ; m_hburst = HBURST_SINGLE; m_hwdata = '0;
    @(posedge clk); #1;
    m_hsel = 1'b0; m_htrans = HTRANS_IDLE; m_hwdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hwdata = '0;
    @(negedge clk);
    chk("rst_hready", 32'(obs_ready[cur]), 32'd1);
    chk("rst_hresp", 32'(obs_resp[cur]), 32'd0);
    @(posedge clk); #1;
    add(32'h30, 0, HSIZE_WORD, 0);
    run();
    chk("rst_cycles", 32'(cyc), 32'd5);
    chk("rst_rdata", pop_rd(), 32'h00000A1D);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
